// File: rtl/rv_barrier_ctrl.sv
// ---------------------------------------------------------------------------
// rv_barrier_ctrl
//
// Warp-barrier controller for the RISC-V GPU core. The issue stage presents
// at most one barrier-arrival request per cycle. Each barrier keeps a mask of
// the warps that have arrived and the participant count latched on its first
// arrival. When the population count of the updated mask reaches that count,
// the barrier's mask is cleared and a registered release (barrier id plus
// warp mask) is offered to the warp scheduler.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   req_valid    arrival request valid
//   req_ready    arrival accepted when req_valid & req_ready
//   req_bar_id   barrier targeted by the arrival
//   req_warp_id  arriving warp
//   req_count    participants required (used on the first arrival only)
//   rel_valid    release pending
//   rel_ready    scheduler accepts the release
//   rel_bar_id   barrier being released
//   rel_mask     warps to release
//   stall_mask   OR of all arrival masks (warps currently waiting)
//   bar_active   bit b set when barrier b has at least one arrival
//   dup_err      one-cycle pulse after accepting an already-arrived warp
// ---------------------------------------------------------------------------
module rv_barrier_ctrl #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int BW           = $clog2(NUM_BARRIERS),
    parameter int WW           = $clog2(NUM_WARPS),
    parameter int CW           = $clog2(NUM_WARPS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [BW-1:0]           req_bar_id,
    input  logic [WW-1:0]           req_warp_id,
    input  logic [CW-1:0]           req_count,
    output logic                    rel_valid,
    input  logic                    rel_ready,
    output logic [BW-1:0]           rel_bar_id,
    output logic [NUM_WARPS-1:0]    rel_mask,
    output logic [NUM_WARPS-1:0]    stall_mask,
    output logic [NUM_BARRIERS-1:0] bar_active,
    output logic                    dup_err
);

    // Popcount tree is built over a power-of-two leaf count; unused leaves are 0.
    localparam int PW = 1 << $clog2(NUM_WARPS);

    // Pairwise adder tree: each pass halves the number of partial sums.
    function automatic logic [CW-1:0] popcount(input logic [NUM_WARPS-1:0] v);
        logic [PW-1:0] v_pad;
        logic [CW-1:0] s [PW];
        v_pad = PW'(v);
        for (int k = 0; k < PW; k++) begin
            s[k] = CW'(v_pad[k]);
        end
        for (int w = PW / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                s[i] = s[2*i] + s[2*i+1];
            end
        end
        return s[0];
    endfunction

    logic [NUM_WARPS-1:0]    r_mask [NUM_BARRIERS];
    logic [CW-1:0]           r_cnt  [NUM_BARRIERS];
    logic                    r_rel_valid;
    logic [BW-1:0]           r_rel_bar_id;
    logic [NUM_WARPS-1:0]    r_rel_mask;
    logic                    r_dup_err;

    logic                    w_accept;
    logic [NUM_WARPS-1:0]    w_onehot;
    logic [NUM_WARPS-1:0]    w_cur_mask;
    logic [NUM_WARPS-1:0]    w_new_mask;
    logic                    w_first;
    logic                    w_dup;
    logic [CW-1:0]           w_pc;
    logic [CW-1:0]           w_eff_raw;
    logic [CW-1:0]           w_eff;
    logic                    w_release;
    logic [NUM_WARPS-1:0]    w_stall;
    logic [NUM_BARRIERS-1:0] w_bar_active;

    // Only one release register: stop accepting while a release is stuck.
    assign req_ready  = !r_rel_valid || rel_ready;
    assign w_accept   = req_valid && req_ready;

    assign w_onehot   = NUM_WARPS'(1) << req_warp_id;
    assign w_cur_mask = r_mask[req_bar_id];
    assign w_new_mask = w_cur_mask | w_onehot;
    assign w_first    = (w_cur_mask == '0);
    assign w_dup      = |(w_cur_mask & w_onehot);
    assign w_pc       = popcount(w_new_mask);

    // Count is latched on the first arrival; later req_count values are ignored.
    // A count of zero behaves like one so a lone arrival still releases.
    assign w_eff_raw  = w_first ? req_count : r_cnt[req_bar_id];
    assign w_eff      = (w_eff_raw == '0) ? CW'(1) : w_eff_raw;
    assign w_release  = (w_pc >= w_eff);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_stall      = '0;
        w_bar_active = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            w_stall         = w_stall | r_mask[b];
            w_bar_active[b] = |r_mask[b];
        end
    end

    // NOTE: the mask/count arrays are small flop arrays, not RAM, so they are
    // reset together with the rest of the state; a reset must drop all arrivals.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_mask[b] <= '0;
                r_cnt[b]  <= '0;
            end
            r_rel_valid  <= 1'b0;
            r_rel_bar_id <= '0;
            r_rel_mask   <= '0;
            r_dup_err    <= 1'b0;
        end else begin
            r_dup_err <= w_accept && w_dup;

            if (w_accept) begin
                if (w_first) begin
                    r_cnt[req_bar_id] <= req_count;
                end
                // Clearing the mask on the release edge keeps released warps
                // out of stall_mask from the cycle rel_valid rises.
                if (w_release) begin
                    r_mask[req_bar_id] <= '0;
                end else begin
                    r_mask[req_bar_id] <= w_new_mask;
                end
            end

            // A new release overwrites the output register even while the
            // previous one is being consumed (back-to-back releases).
            if (w_accept && w_release) begin
                r_rel_valid  <= 1'b1;
                r_rel_bar_id <= req_bar_id;
                r_rel_mask   <= w_new_mask;
            end else if (rel_ready) begin
                r_rel_valid  <= 1'b0;
            end
        end
    end

    assign rel_valid  = r_rel_valid;
    assign rel_bar_id = r_rel_bar_id;
    assign rel_mask   = r_rel_mask;
    assign dup_err    = r_dup_err;
    assign stall_mask = w_stall;
    assign bar_active = w_bar_active;

endmodule

// File: tb/tb_rv_barrier_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_barrier_ctrl
//
// Directed bench for rv_barrier_ctrl. Expected releases are queued when the
// completing arrival is driven; a monitor pops and compares them whenever the
// scheduler side consumes a release. Side-band outputs are checked directly.
// ---------------------------------------------------------------------------
module tb_rv_barrier_ctrl;

    localparam int NW = 4;
    localparam int NB = 4;
    localparam int BW = 2;
    localparam int WW = 2;
    localparam int CW = 3;

    typedef struct {
        logic [BW-1:0] bar;
        logic [NW-1:0] mask;
    } rel_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [BW-1:0] req_bar_id;
    logic [WW-1:0] req_warp_id;
    logic [CW-1:0] req_count;
    logic          rel_valid;
    logic          rel_ready;
    logic [BW-1:0] rel_bar_id;
    logic [NW-1:0] rel_mask;
    logic [NW-1:0] stall_mask;
    logic [NB-1:0] bar_active;
    logic          dup_err;

    rel_t exp_q [$];
    int   n_checks = 0;
    int   n_fails  = 0;

    rv_barrier_ctrl #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_bar_id  (req_bar_id),
        .req_warp_id (req_warp_id),
        .req_count   (req_count),
        .rel_valid   (rel_valid),
        .rel_ready   (rel_ready),
        .rel_bar_id  (rel_bar_id),
        .rel_mask    (rel_mask),
        .stall_mask  (stall_mask),
        .bar_active  (bar_active),
        .dup_err     (dup_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int bar, input int warp, input int cnt);
        req_valid   = 1'b1;
        req_bar_id  = BW'(bar);
        req_warp_id = WW'(warp);
        req_count   = CW'(cnt);
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic expect_rel(input int bar, input logic [NW-1:0] mask);
        rel_t e;
        e.bar  = BW'(bar);
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    // Step to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a release is consumed when rel_valid & rel_ready at the edge.
    always @(negedge clk) begin
        if (!reset && rel_valid && rel_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_release: bar %0d mask %b, none expected", rel_bar_id, rel_mask);
            end else begin
                rel_t e;
                e = exp_q.pop_front();
                check("rel_bar_id", 32'(rel_bar_id), 32'(e.bar));
                check("rel_mask",   32'(rel_mask),   32'(e.mask));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_bar_id  = '0;
        req_warp_id = '0;
        req_count   = '0;
        rel_ready   = 1'b1;
        #12;
        check("rst_rel_valid",  32'(rel_valid),  0);
        check("rst_rel_mask",   32'(rel_mask),   0);
        check("rst_stall",      32'(stall_mask), 0);
        check("rst_bar_active", 32'(bar_active), 0);
        check("rst_dup_err",    32'(dup_err),    0);
        @(negedge clk);
        reset = 1'b0;

        // Four-warp barrier on bar 1, count 4.
        drive(1, 0, 4); step();
        check("t1_stall_0001", 32'(stall_mask), 32'b0001);
        check("t1_active",     32'(bar_active), 32'b0010);
        drive(1, 1, 4); step();
        check("t1_stall_0011", 32'(stall_mask), 32'b0011);
        drive(1, 2, 4); step();
        check("t1_stall_0111", 32'(stall_mask), 32'b0111);
        check("t1_no_rel",     32'(rel_valid),  0);
        drive(1, 3, 4); expect_rel(1, 4'b1111); step(); idle();
        check("t1_rel_valid",  32'(rel_valid),  1);
        check("t1_stall_0000", 32'(stall_mask), 0);
        check("t1_active_0",   32'(bar_active), 0);
        step();
        check("t1_rel_drop",   32'(rel_valid),  0);

        // Count latched at 2; a later count of 4 is ignored.
        drive(0, 3, 2); step();
        check("t2_stall",      32'(stall_mask), 32'b1000);
        check("t2_rel_none",   32'(rel_valid),  0);
        drive(0, 1, 4); expect_rel(0, 4'b1010); step(); idle();
        check("t2_rel_valid",  32'(rel_valid),  1);
        check("t2_stall_0",    32'(stall_mask), 0);
        step();

        // Count 0 behaves as 1: immediate release, barrier never active.
        drive(2, 2, 0); expect_rel(2, 4'b0100); step(); idle();
        check("t3_rel_valid",  32'(rel_valid),  1);
        check("t3_active",     32'(bar_active), 0);
        step();

        // Backpressure: release held, no acceptance, outputs stable.
        rel_ready = 1'b0;
        drive(0, 0, 1); expect_rel(0, 4'b0001); step();
        drive(3, 3, 1);
        check("t4_rel_valid",  32'(rel_valid),  1);
        check("t4_not_ready",  32'(req_ready),  0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_valid", 32'(rel_valid),  1);
            check("t4_hold_bar",   32'(rel_bar_id), 0);
            check("t4_hold_mask",  32'(rel_mask),   32'b0001);
            check("t4_hold_stall", 32'(stall_mask), 0);
        end
        // Raise rel_ready with the request still valid: both happen at once.
        rel_ready = 1'b1;
        #1;
        check("t4_ready_back", 32'(req_ready), 1);
        expect_rel(3, 4'b1000);
        step(); idle();
        check("t4_new_valid",  32'(rel_valid),  1);
        check("t4_new_bar",    32'(rel_bar_id), 3);
        step();

        // Duplicate arrival of warp 1 at bar 2.
        drive(2, 1, 3); step();
        check("t5_dup_first",  32'(dup_err),    0);
        drive(2, 1, 3); step(); idle();
        check("t5_dup_pulse",  32'(dup_err),    1);
        check("t5_stall",      32'(stall_mask), 32'b0010);
        check("t5_no_rel",     32'(rel_valid),  0);
        step();
        check("t5_dup_clear",  32'(dup_err),    0);
        check("t5_active",     32'(bar_active), 32'b0100);

        // Async reset with bar 3 = 0110 and a stuck release pending.
        drive(3, 1, 4); step();
        drive(3, 2, 4); step();
        check("t6_stall",      32'(stall_mask), 32'b0110);
        check("t6_active",     32'(bar_active), 32'b1100);
        rel_ready = 1'b0;
        drive(0, 0, 1); step(); idle();
        check("t6_pending",    32'(rel_valid),  1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid",  32'(rel_valid),  0);
        check("t6_rst_bar",    32'(rel_bar_id), 0);
        check("t6_rst_mask",   32'(rel_mask),   0);
        check("t6_rst_stall",  32'(stall_mask), 0);
        check("t6_rst_active", 32'(bar_active), 0);
        @(negedge clk);
        reset     = 1'b0;
        rel_ready = 1'b1;
        drive(3, 3, 1); expect_rel(3, 4'b1000); step(); idle();
        check("t6_after_valid", 32'(rel_valid), 1);
        check("t6_after_mask",  32'(rel_mask),  32'b1000);
        step();
        step();

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rv_barrier_ctrl.md
Name: rv_barrier_ctrl

Overview:
- Warp-barrier controller for the RISC-V GPU core.
- Accepts barrier-arrival requests from the issue stage, one per cycle, and keeps a per-barrier arrival mask of warps. A population count of that mask is compared against the requested participant count.
- When enough warps have arrived, it emits a registered release (barrier id plus warp mask) to the warp scheduler.
- It drives the stall mask the scheduler uses to hold arrived warps.

Parameters:
- NUM_WARPS, 4, warps per core (arrival mask width); >=2.
- NUM_BARRIERS, 4, independent barriers; >=2.
- BW, $clog2(NUM_BARRIERS), barrier id width.
- WW, $clog2(NUM_WARPS), warp id width.
- CW, $clog2(NUM_WARPS+1), participant-count width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  1  arrival request valid.
- req_ready  out  1  arrival request accepted when req_valid&req_ready.
- req_bar_id  in  BW  barrier targeted.
- req_warp_id  in  WW  arriving warp.
- req_count  in  CW  participants required for release.
- rel_valid  out  1  release pending.
- rel_ready  in  1  scheduler accepts release.
- rel_bar_id  out  BW  barrier being released.
- rel_mask  out  NUM_WARPS  warps to release.
- stall_mask  out  NUM_WARPS  OR of all barrier arrival masks (warps currently waiting).
- bar_active  out  NUM_BARRIERS  bit b set when barrier b has >=1 arrival.
- dup_err  out  1  one-cycle pulse: accepted request whose warp was already set in that barrier.

Behaviour:
- Clock and reset: single clock `clk`. `reset` is asynchronous and active-high.
- Reset: all arrival masks 0; rel_valid=0; rel_bar_id=0; rel_mask=0; dup_err=0; stall_mask=0; bar_active=0.
- Per-barrier state:
  - mask[b] (NUM_WARPS bits).
  - cnt[b] (CW bits): latched from req_count on the first arrival to b; later arrivals' req_count is ignored.
- req_ready = !rel_valid | rel_ready. Single release output register, so no acceptance while a release is stuck.
- On accept:
  - Compute new_mask = mask[b] | onehot(req_warp_id).
  - Compute pc = popcount(new_mask), tree form, CW bits.
  - eff = (first arrival ? req_count : cnt[b]). eff==0 is treated as 1.
  - If pc >= eff (release case), next cycle:
    - rel_valid=1, rel_bar_id=b, rel_mask=new_mask;
    - mask[b] cleared in the same edge;
    - bar_active[b]=0.
  - Else mask[b] <= new_mask.
- Latency: accept at edge N -> rel_valid high after edge N. Held until rel_valid&rel_ready.
- Release handshake: on rel_ready with no new release, rel_valid drops next cycle. Release-and-accept in the same cycle replaces the output register (back-to-back releases allowed).
- stall_mask and bar_active are combinational from the mask registers. A released warp is not in stall_mask from the cycle rel_valid rises.
- Duplicate arrival (bit already set in mask[b]):
  - mask unchanged; dup_err pulses one cycle;
  - release check still evaluated (pc unchanged, so no release unless already satisfied — cannot happen).
- The same warp may sit in two barriers; no check is made across barriers.
- req_count > NUM_WARPS: the barrier never releases until reset. Documented software error; no detection.
- Reset mid-operation: all state cleared immediately; a pending release is discarded.
- Request to barrier b in the cycle after b released: treated as a first arrival with a fresh cnt latch.

Test Plan:
- Four-warp barrier: count=4 on bar 1, warps 0,1,2,3 on consecutive cycles, rel_ready=1 -> stall_mask grows 0001,0011,0111; rel_valid one cycle after the 4th accept, rel_bar_id=1, rel_mask=1111; stall_mask=0000 the same cycle.
- Partial count with later mismatched count: bar 0 count=2 from warp 3, then warp 1 with count=4 -> release rel_mask=1010 (cnt latched at 2).
- Count 0 and 1: single arrival of warp 2 with count=0 -> immediate release next cycle, rel_mask=0100; bar_active stays 0.
- Backpressure: hold rel_ready=0 after a release -> req_ready=0; rel_bar_id/rel_mask stable for 5 cycles; raise rel_ready with a valid request the same cycle -> request accepted, old release consumed.
- Duplicate: warp 1 arrives twice at bar 2 with count=3 -> dup_err pulses once; mask=0010; no release.
- Async reset asserted with bar 3 holding mask 0110 and a rel_valid pending -> all outputs 0 without a clock edge; after deassert, a fresh count=1 arrival releases normally.
